// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle LEGv8 control sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK
  } stateT;

  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_ADDI, CLS_LDUR, CLS_STUR, CLS_CBZ, CLS_B, CLS_MOVZ
  } instrClassT;

  // Opcode patterns on Instruction[31:21]; '?' bits are operand fields.
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDI = 11'b1001000100?;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100???;
  localparam logic [10:0] OP_B    = 11'b000101?????;
  localparam logic [10:0] OP_MOVZ = 11'b110100101??;

  localparam logic [2:0] SIGN_B    = 3'b000;
  localparam logic [2:0] SIGN_CB   = 3'b001;
  localparam logic [2:0] SIGN_D    = 3'b010;
  localparam logic [2:0] SIGN_I    = 3'b011;
  localparam logic       SIGN_MOVZ = 1'b1;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps the latched opcode to datapath controls.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output instrClassT  cls,
  output logic [2:0]  signOp,
  output logic        aluSrc,
  output logic [3:0]  aluCtrl,
  output logic        reg2Loc,
  output logic        memtoReg,
  output logic        legal
);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    cls      = CLS_RTYPE;
    signOp   = SIGN_B;
    aluSrc   = 1'b0;
    aluCtrl  = ALU_AND;
    reg2Loc  = 1'b0;
    memtoReg = 1'b0;
    legal    = 1'b1;
    casez (opcode)
      OP_ADD: aluCtrl = ALU_ADD;
      OP_SUB: aluCtrl = ALU_SUB;
      OP_AND: aluCtrl = ALU_AND;
      OP_ORR: aluCtrl = ALU_ORR;
      OP_ADDI: begin
        cls = CLS_ADDI; signOp = SIGN_I; aluSrc = 1'b1; aluCtrl = ALU_ADD;
      end
      OP_LDUR: begin
        cls = CLS_LDUR; signOp = SIGN_D; aluSrc = 1'b1; aluCtrl = ALU_ADD;
        memtoReg = 1'b1;
      end
      OP_STUR: begin
        cls = CLS_STUR; signOp = SIGN_D; aluSrc = 1'b1; aluCtrl = ALU_ADD;
        reg2Loc = 1'b1;
      end
      OP_CBZ: begin
        cls = CLS_CBZ; signOp = SIGN_CB; aluCtrl = ALU_PASSB; reg2Loc = 1'b1;
      end
      OP_B: cls = CLS_B;
      OP_MOVZ: begin
        // Low two opcode bits are the hw shift field.
        cls = CLS_MOVZ; signOp = {SIGN_MOVZ, opcode[1:0]}; aluSrc = 1'b1;
        aluCtrl = ALU_PASSB;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control sequencer: FSM, opcode register and memory timeout.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [31:0] Instruction,
  input  logic        Zero,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        IRWrite,
  output logic [2:0]  SignOp,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic [3:0]  ALUCtrl,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        illegal,
  output logic        bus_err
);

  localparam int CW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

  stateT         state, stateNext;
  logic [10:0]   opcode;
  logic [CW-1:0] waitCnt;
  logic          atLimit, waiting, restart;

  instrClassT cls;
  logic [2:0] decSignOp;
  logic [3:0] decAluCtrl;
  logic       decAluSrc, decReg2Loc, decMemtoReg, decLegal;

  // Operand fields are consumed by the datapath, not by control.
  logic unusedInstr;
  assign unusedInstr = ^Instruction[20:0];

  ctrl_decode uDecode (
    .opcode   (opcode),
    .cls      (cls),
    .signOp   (decSignOp),
    .aluSrc   (decAluSrc),
    .aluCtrl  (decAluCtrl),
    .reg2Loc  (decReg2Loc),
    .memtoReg (decMemtoReg),
    .legal    (decLegal)
  );

  assign atLimit = (waitCnt == LIMIT);
  assign waiting = (state == FETCH && !imem_ack) || (state == MEMORY && !dmem_ack);
  // A timeout retry re-enters FETCH from FETCH, so it must clear the counter too.
  assign restart = (stateNext == FETCH || stateNext == MEMORY) &&
                   (stateNext != state || bus_err);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state   <= IDLE;
      opcode  <= '0;
      waitCnt <= '0;
    end else begin
      state <= stateNext;
      if (IRWrite) opcode <= Instruction[31:21];
      if (restart)      waitCnt <= '0;
      else if (waiting) waitCnt <= waitCnt + 1'b1;
    end
  end

  always_comb begin
    stateNext = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    IRWrite   = 1'b0;
    SignOp    = SIGN_B;
    Reg2Loc   = 1'b0;
    ALUSrc    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUCtrl   = ALU_AND;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;

    // Decoded datapath controls stay stable for the whole instruction.
    if (state inside {DECODE, EXECUTE, MEMORY, WRITEBACK}) begin
      SignOp   = decSignOp;
      ALUSrc   = decAluSrc;
      ALUCtrl  = decAluCtrl;
      MemtoReg = decMemtoReg;
    end

    case (state)
      IDLE: stateNext = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          IRWrite   = 1'b1;
          stateNext = DECODE;
        end else if (atLimit) begin
          bus_err   = 1'b1;
          stateNext = FETCH;
        end
      end
      DECODE: begin
        Reg2Loc = decReg2Loc;
        if (!decLegal) begin
          illegal   = 1'b1;
          PCWrite   = 1'b1;
          stateNext = FETCH;
        end else begin
          stateNext = EXECUTE;
        end
      end
      EXECUTE: begin
        case (cls)
          CLS_B: begin
            PCWrite = 1'b1; PCSrc = 1'b1; stateNext = FETCH;
          end
          CLS_CBZ: begin
            PCWrite = 1'b1; PCSrc = Zero; stateNext = FETCH;
          end
          CLS_LDUR, CLS_STUR: stateNext = MEMORY;
          default:            stateNext = WRITEBACK;
        endcase
      end
      MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CLS_STUR);
        if (dmem_ack) begin
          if (cls == CLS_STUR) begin
            PCWrite   = 1'b1;
            stateNext = FETCH;
          end else begin
            stateNext = WRITEBACK;
          end
        end else if (atLimit) begin
          bus_err   = 1'b1;
          stateNext = FETCH;
        end
      end
      WRITEBACK: begin
        RegWrite  = 1'b1;
        PCWrite   = 1'b1;
        stateNext = FETCH;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control sequencer for the multi-cycle LEGv8 core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the imem/dmem request handshakes and configures the shared datapath blocks: the sign extender's 3-bit `SignOp`, the ALU control and the register-file, mux and PC enables. It sits beside the datapath and replaces the combinational single-cycle control unit.

## Interface
- `MEM_TIMEOUT`, default 16: cycles a memory request may wait without ack before it is aborted.
- `CLK`  in  1  system clock, rising edge.
- `resetl`  in  1  asynchronous, active-low reset.
- `Instruction`  in  32  instruction word from imem, valid while `imem_ack`=1.
- `Zero`  in  1  ALU zero flag, sampled in EXECUTE.
- `imem_ack`, `dmem_ack`  in  1  memory acknowledges.
- `imem_req`, `dmem_req`  out  1  memory requests.
- `dmem_we`  out  1  1 = store, qualifies `dmem_req`.
- `IRWrite`  out  1  latch instruction register.
- `SignOp`  out  3  sign-extender select: B=000, CB=001, D=010, I=011, MOVZ=1,hw.
- `Reg2Loc`, `ALUSrc`, `MemtoReg`, `RegWrite`  out  1  datapath selects and enables.
- `ALUCtrl`  out  4  AND=0000, ORR=0001, ADD=0010, SUB=0110, PassB=0111.
- `PCWrite`  out  1  update PC this cycle.
- `PCSrc`  out  1  0 = PC+4, 1 = branch target.
- `illegal`, `bus_err`  out  1  one-cycle error pulses.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
- Supported opcodes (Instruction[31:21]):
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - ADDI 1001000100x.
  - LDUR 11111000010, STUR 11111000000.
  - CBZ 10110100xxx, B 000101xxxxx.
  - MOVZ 110100101xx; hw = Instruction[22:21].
- The opcode is held in an internal 11-bit register, loaded when `IRWrite`=1.
- IDLE → FETCH unconditionally.
- FETCH:
  - `imem_req`=1.
  - On `imem_ack`: `IRWrite`=1, then → DECODE.
- DECODE:
  - `Reg2Loc`=1 for STUR and CBZ.
  - Illegal opcode: `illegal`=1, `PCWrite`=1, `PCSrc`=0, → FETCH.
  - Otherwise → EXECUTE.
- EXECUTE:
  - Drives `SignOp` and `ALUSrc`; `ALUSrc`=1 for ADDI, LDUR, STUR, MOVZ.
  - ALU operation per instruction: `ALUCtrl`=ADD for LDUR/STUR, PassB for CBZ/MOVZ.
  - B: `PCWrite`=1, `PCSrc`=1, → FETCH.
  - CBZ: `PCWrite`=1, `PCSrc`=`Zero`, → FETCH.
  - LDUR/STUR → MEMORY; all others → WRITEBACK.
- MEMORY:
  - `dmem_req`=1; `dmem_we`=1 for STUR.
  - On `dmem_ack`: STUR asserts `PCWrite`=1, `PCSrc`=0, → FETCH; LDUR → WRITEBACK.
- WRITEBACK:
  - `RegWrite`=1, `PCWrite`=1, `PCSrc`=0.
  - `MemtoReg`=1 for LDUR.
  - → FETCH.
- `SignOp`, `ALUSrc`, `ALUCtrl` and `MemtoReg` hold their decoded values from DECODE through WRITEBACK. Datapath registers therefore see stable controls.
- Timeout:
  - A counter clears on entry to FETCH/MEMORY and increments each cycle the request is held without ack.
  - When it reaches `MEM_TIMEOUT`-1 with no ack: drop the request, `bus_err`=1, no `PCWrite`, → FETCH. This retries the same PC.
  - An ack in the same cycle as the limit wins; no `bus_err`.

## Timing
- Reset: state IDLE; opcode register 0; all outputs 0; counter 0.
- `imem_req` first rises one cycle after `resetl` deasserts.
- `resetl` low mid-instruction aborts immediately, with no PC or register write.
- The handshake is level-based:
  - The request stays high until the cycle ack=1, including the ack cycle.
  - Ack with no request pending is ignored.
  - Zero-wait ack (ack in the first request cycle) is legal.
- Latency with zero-wait memory:
  - B/CBZ: 3 cycles.
  - R-type, ADDI, MOVZ: 4 cycles.
  - STUR: 4 cycles.
  - LDUR: 5 cycles.
  - Each memory wait cycle adds one.
- All outputs are Moore decodes of state plus the opcode register, except `IRWrite` (FETCH and `imem_ack`), the MEMORY-exit `PCWrite`, and `PCSrc` for CBZ (follows `Zero`).
- `PCWrite` is exactly one cycle per retired or illegal instruction; never on timeout.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum;
  - opcode match constants;
  - `SignOp` encodings;
  - `ALUCtrl` codes.
- Combinational sub-module `ctrl_decode` maps the opcode register to {class, `SignOp`, `ALUSrc`, `ALUCtrl`, `Reg2Loc`, `MemtoReg`, legal}.
- The top level holds the FSM, opcode register and timeout counter.

## Test plan
- Reset, then ADD 0x8B020020 with zero-wait imem → `IRWrite` at cycle 1, `RegWrite`+`PCWrite` at cycle 4, `ALUCtrl`=0010.
- LDUR 0xF84083E1 with 3-cycle `dmem_ack` delay → `dmem_req` high 3 cycles, `dmem_we`=0, `SignOp`=010, WRITEBACK `MemtoReg`=1.
- CBZ 0xB4000060 run twice, with `Zero`=1 then `Zero`=0 → `PCSrc`=1 then 0, `SignOp`=001, no `RegWrite`.
- MOVZ hw=3 (0xD2E00020) → `SignOp`=111, `ALUCtrl`=0111, `RegWrite` at WRITEBACK.
- `imem_ack` never asserts with `MEM_TIMEOUT`=16 → `bus_err` pulse after 16 request cycles, FETCH retried, no `PCWrite`.
- Opcode 0x000 → `illegal`=1 and `PCWrite`=1 in DECODE. Separately, `resetl` pulsed low during MEMORY of a STUR → `dmem_req` 0 at once, state IDLE.
